wb_walker_master: RTL and testbench
===================================

Name: wb_walker_master

Overview:
- Pipelined Wishbone initiator that drives the LED request-walker peripheral from the bus-master side.
- On a one-cycle trigger it writes a start word to the walker, then polls the walker's status register with reads until the walker reports idle.
- It reports completion or error to local control logic.
- It sits between a local control FSM and the walker's slave port: one master, one slave, no arbitration.

Parameters:
- DW, 32, data bus width.
- START_WORD, 32'h0000_0001, value written at addr 0 to launch a walk.
- POLL_GAP, 4, idle cycles between consecutive status reads (1..255).
- ACK_TIMEOUT, 16, max cycles from strobe acceptance to i_ack before abort (2..255).
- MAX_POLLS, 64, max status reads per walk before error (1..255).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_trigger  in  1  start request; sampled only when o_busy=0
- o_busy  out  1  operation in progress
- o_done  out  1  one-cycle pulse: walk completed (status read returned 0)
- o_err  out  1  one-cycle pulse: ack timeout or poll limit reached
- o_polls  out  8  status reads issued in current/last operation
- o_cyc  out  1  Wishbone cycle
- o_stb  out  1  Wishbone strobe
- o_we  out  1  write enable
- o_addr  out  1  address (always 0 in this block)
- o_data  out  DW  write data
- i_stall  in  1  slave stall
- i_ack  in  1  slave acknowledge
- i_data  in  DW  slave read data

Behaviour:
- Reset (async assert, sync release): state=IDLE. o_cyc=o_stb=o_we=o_busy=o_done=o_err=0, o_addr=0, o_data=0, o_polls=0, counters=0.
- States:
  - IDLE
  - WR_REQ: cyc=1, stb=1, we=1, data=START_WORD
  - WR_ACK: cyc=1, stb=0
  - GAP: cyc=0, counts POLL_GAP
  - RD_REQ: cyc=1, stb=1, we=0
  - RD_ACK: cyc=1, stb=0
- IDLE & i_trigger: go to WR_REQ next cycle; o_busy=1 from that cycle; o_polls cleared.
- xx_REQ: o_stb held until a cycle with i_stall=0 (accepted). Next state is xx_ACK, or DONE/GAP directly if i_ack arrives in the same cycle as acceptance.
- xx_ACK: wait for i_ack with o_cyc held. The ack counter starts at acceptance. When it reaches ACK_TIMEOUT without ack: drop cyc, pulse o_err, go to IDLE.
- WR ack: go to GAP.
- GAP: POLL_GAP cycles of cyc=0, then RD_REQ; o_polls increments on entry to RD_REQ.
- RD ack:
  - i_data==0: pulse o_done, go to IDLE.
  - otherwise, if o_polls==MAX_POLLS: pulse o_err, go to IDLE.
  - else: go to GAP.
- o_busy drops in the same cycle o_done/o_err pulses. o_done and o_err are never both 1.
- o_stb is never 1 while o_cyc is 0. o_we and o_data are stable while o_stb=1.
- i_ack while o_cyc=0 (stray) is ignored.
- i_trigger while busy is ignored, not queued.
- Reset mid-transaction drops o_cyc asynchronously. No done/err pulse.
- Counters: 8-bit saturating; no wrap.

Decomposition:
- Package wb_walker_pkg: state enum, WALKER_CTRL_ADDR=1'b0, default START_WORD.
- One sub-module is natural: wb_ack_timer (load/count/expire on ACK_TIMEOUT), reused by later masters.

Test Plan:
- Trigger, slave acks in 1 cycle with no stall, reads return 3,2,0 -> one write of 32'h1; 3 reads spaced by 4 idle cycles; o_done at the 3rd ack; o_polls=3.
- Write held with i_stall=1 for 5 cycles -> o_stb stays 1 and o_we/o_data stay stable for 6 cycles; exactly one accepted write.
- Slave never acks -> o_cyc drops and o_err pulses 16 cycles after acceptance; o_busy=0; no o_done.
- MAX_POLLS=3, reads always return 1 -> o_err after the 3rd read ack; o_polls=3.
- i_reset asserted during RD_ACK -> o_cyc=0 immediately (asynchronous); all outputs at reset values; next trigger runs a clean sequence.
- i_trigger held high through a walk, plus stray i_ack in IDLE -> no second write until the walk ends; stray ack causes no output change.

Source files
------------

// File: rtl/wb_walker_pkg.sv
// Shared types and constants for the Wishbone LED-walker bus master.
package wb_walker_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic        WALKER_CTRL_ADDR   = 1'b0;
    localparam logic [31:0] DEFAULT_START_WORD = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_ACK = 3'd2,
        ST_GAP    = 3'd3,
        ST_RD_REQ = 3'd4,
        ST_RD_ACK = 3'd5
    } walker_state_e;

    // Saturating increment for the 8-bit bookkeeping counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Acknowledge watchdog: cleared when a strobe is accepted, counts waiting cycles,
// flags the cycle in which the next miss would reach LIMIT.
module wb_ack_timer
    import wb_walker_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q, expire_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = sat_inc(count_q);
        end
        expire_d = (count_d == CNT_W'(LIMIT - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/wb_walker_master.sv
// Pipelined Wishbone initiator: writes the start word to the LED walker, then
// polls its status register until it reads back idle, a poll limit, or an ack timeout.
module wb_walker_master
    import wb_walker_pkg::*;
#(
    parameter int unsigned    DW          = 32,
    parameter logic [DW-1:0]  START_WORD  = DW'(DEFAULT_START_WORD),
    parameter int unsigned    POLL_GAP    = 4,
    parameter int unsigned    ACK_TIMEOUT = 16,
    parameter int unsigned    MAX_POLLS   = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_trigger,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [7:0]    o_polls,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic          o_addr,
    output logic [DW-1:0] o_data,
    input  logic          i_stall,
    input  logic          i_ack,
    input  logic [DW-1:0] i_data
);

    walker_state_e    state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] polls_q, polls_d;
    logic [DW-1:0]    data_q, data_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic accept;
    logic waiting;
    logic ack;
    logic timeout;
    logic expire;

    // Bus handshake qualifiers; acks outside an open request are never looked at.
    assign accept  = ((state_q == ST_WR_REQ) || (state_q == ST_RD_REQ)) && !i_stall;
    assign waiting = (state_q == ST_WR_ACK) || (state_q == ST_RD_ACK);
    assign ack     = (accept || waiting) && i_ack;
    assign timeout = waiting && !i_ack && expire;

    wb_ack_timer #(
        .LIMIT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .load_i  (accept),
        .count_i (waiting && !i_ack),
        .expire_o(expire)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = '0;
        polls_d = polls_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_trigger) begin
                    state_d = ST_WR_REQ;
                    polls_d = '0;
                    data_d  = START_WORD;
                end
            end
            ST_WR_REQ, ST_WR_ACK: begin
                if (ack) begin
                    state_d = ST_GAP;
                end else if (accept) begin
                    state_d = ST_WR_ACK;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == CNT_W'(POLL_GAP - 1)) begin
                    state_d = ST_RD_REQ;
                    polls_d = sat_inc(polls_q);
                end else begin
                    gap_d = sat_inc(gap_q);
                end
            end
            ST_RD_REQ, ST_RD_ACK: begin
                if (ack) begin
                    // A zero status word means the walker has gone idle.
                    if (i_data == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (polls_q == CNT_W'(MAX_POLLS)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (accept) begin
                    state_d = ST_RD_ACK;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cyc_d  = (state_d == ST_WR_REQ) || (state_d == ST_WR_ACK) ||
                 (state_d == ST_RD_REQ) || (state_d == ST_RD_ACK);
        stb_d  = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        we_d   = (state_d == ST_WR_REQ) || (state_d == ST_WR_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            polls_q <= '0;
            data_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            polls_q <= polls_d;
            data_q  <= data_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_polls = polls_q;
    assign o_cyc   = cyc_q;
    assign o_stb   = stb_q;
    assign o_we    = we_q;
    assign o_addr  = WALKER_CTRL_ADDR;
    assign o_data  = data_q;

endmodule

// File: tb/tb_wb_walker_master.sv
// Randomized bench for wb_walker_master: a behavioural slave plays out a per-walk plan
// and a transaction-level model predicts every bus phase, pulse and the final outcome.
module tb_wb_walker_master;

    localparam int unsigned DW          = 32;
    localparam logic [31:0] START_WORD  = 32'h0000_0001;
    localparam int unsigned POLL_GAP    = 4;
    localparam int unsigned ACK_TIMEOUT = 16;
    localparam int unsigned MAX_POLLS   = 3;
    localparam int          NEVER       = 1000;
    localparam int          N_TXN       = MAX_POLLS + 1;
    localparam int          WALK_BOUND  = 500;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_trigger;
    logic          o_busy, o_done, o_err, o_cyc, o_stb, o_we, o_addr;
    logic [7:0]    o_polls;
    logic [DW-1:0] o_data;
    logic          i_stall, i_ack;
    logic [DW-1:0] i_data;

    always #5 clk = ~clk;

    wb_walker_master #(
        .DW         (DW),
        .START_WORD (START_WORD),
        .POLL_GAP   (POLL_GAP),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MAX_POLLS  (MAX_POLLS)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_trigger(i_trigger),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_err    (o_err),
        .o_polls  (o_polls),
        .o_cyc    (o_cyc),
        .o_stb    (o_stb),
        .o_we     (o_we),
        .o_addr   (o_addr),
        .o_data   (o_data),
        .i_stall  (i_stall),
        .i_ack    (i_ack),
        .i_data   (i_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-walk plan: index 0 is the start write, index k is the k-th status read.
    int          stall_plan[N_TXN];
    int          lat_plan[N_TXN];
    logic [31:0] val_plan[MAX_POLLS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return NEVER;
        if (r == 1) return int'(ACK_TIMEOUT);
        return int'($urandom_range(0, 3));
    endfunction

    task automatic run_walk(input bit hold_trig, input bit rst_mode);
        int exp_kind, exp_reads;
        int txn, reads, wr_accepts, wr_stb_cycles;
        int stall_rem, lat, wait_cnt, gap_run, cycles, kind;
        bit in_req, waiting, drove_accept, drove_ack, ended;
        bit exp_done, exp_err;

        // Outcome model: 0 = done, 1 = error; reads = status reads issued.
        exp_kind  = 1;
        exp_reads = 0;
        if (lat_plan[0] != NEVER) begin
            for (int i = 0; i < int'(MAX_POLLS); i++) begin
                exp_reads = i + 1;
                if (lat_plan[i+1] == NEVER) break;
                if (val_plan[i] == 32'd0) begin
                    exp_kind = 0;
                    break;
                end
            end
        end

        txn = 0; reads = 0; wr_accepts = 0; wr_stb_cycles = 0;
        stall_rem = 0; lat = 0; wait_cnt = 0; gap_run = 0; cycles = 0; kind = -1;
        in_req = 0; waiting = 0; drove_accept = 0; drove_ack = 0; ended = 0;

        @(negedge clk);
        i_trigger = 1'b1;
        i_ack     = 1'b0;
        @(negedge clk);
        check_eq("busy_on_start", o_busy, 1);
        check_eq("polls_cleared", o_polls, 0);
        if (!hold_trig) i_trigger = 1'b0;

        while (!ended) begin
            check_eq("stb_without_cyc", o_stb & ~o_cyc, 0);
            check_eq("done_and_err", o_done & o_err, 0);

            if (drove_accept) begin
                waiting  = !drove_ack;
                wait_cnt = 0;
                if (txn == 0) wr_accepts++;
            end else if (waiting && !drove_ack) begin
                wait_cnt++;
            end

            if (drove_ack) begin
                waiting = 0;
                gap_run = 0;
                if (txn == 0) begin
                    check_eq("wr_ack_to_gap", {o_cyc, o_busy, o_done, o_err}, 4'b0100);
                end else begin
                    exp_done = (val_plan[txn-1] == 32'd0);
                    exp_err  = !exp_done && (reads == int'(MAX_POLLS));
                    check_eq("rd_ack_done", o_done, exp_done);
                    check_eq("rd_ack_err", o_err, exp_err);
                    check_eq("rd_ack_busy", o_busy, !(exp_done || exp_err));
                    check_eq("rd_ack_cyc", o_cyc, 0);
                    check_eq("rd_ack_polls", o_polls, reads);
                    if (exp_done || exp_err) begin
                        ended = 1;
                        kind  = exp_done ? 0 : 1;
                    end
                end
                txn++;
            end else if (waiting) begin
                if (rst_mode && txn > 0 && wait_cnt == 3) begin
                    rst = 1'b1;
                    #1;
                    check_eq("rst_async_bus", {o_cyc, o_stb, o_we}, 3'b000);
                    check_eq("rst_async_flags", {o_busy, o_done, o_err}, 3'b000);
                    check_eq("rst_async_polls", o_polls, 0);
                    check_eq("rst_async_data", o_data, 0);
                    ended = 1;
                    kind  = 2;
                end else if (wait_cnt == int'(ACK_TIMEOUT)) begin
                    check_eq("timeout_err", {o_err, o_done, o_cyc, o_busy}, 4'b1000);
                    ended = 1;
                    kind  = 1;
                end else begin
                    check_eq("ack_wait_hold", {o_cyc, o_stb, o_err}, 3'b100);
                end
            end

            cycles++;
            if (!ended && cycles > WALK_BOUND) begin
                check_eq("walk_bound", 1, 0);
                ended = 1;
            end

            drove_accept = 0;
            drove_ack    = 0;
            i_stall      = 1'($urandom_range(0, 1));
            i_ack        = 1'b0;
            i_data       = $urandom;
            if (ended) begin
                i_trigger = 1'b0;
                i_stall   = 1'b0;
            end else if (o_stb) begin
                if (!in_req) begin
                    in_req    = 1;
                    stall_rem = stall_plan[txn];
                    lat       = lat_plan[txn];
                    if (txn > 0) begin
                        reads++;
                        check_eq("gap_len", gap_run, POLL_GAP);
                        check_eq("polls_inc", o_polls, reads);
                    end
                end
                if (txn == 0) wr_stb_cycles++;
                check_eq("req_we", o_we, (txn == 0));
                if (txn == 0) check_eq("req_data", o_data, START_WORD);
                check_eq("req_addr", o_addr, 0);
                if (stall_rem > 0) begin
                    i_stall = 1'b1;
                    stall_rem--;
                end else begin
                    i_stall      = 1'b0;
                    drove_accept = 1;
                    in_req       = 0;
                    if (lat == 0) begin
                        i_ack     = 1'b1;
                        drove_ack = 1;
                        if (txn > 0) i_data = val_plan[txn-1];
                    end
                end
            end else if (o_cyc) begin
                if (waiting && lat != NEVER && wait_cnt + 1 == lat) begin
                    i_ack     = 1'b1;
                    drove_ack = 1;
                    if (txn > 0) i_data = val_plan[txn-1];
                end
            end else begin
                gap_run++;
                i_ack = ($urandom_range(0, 3) == 0);
            end

            if (!ended) @(negedge clk);
        end

        if (kind == 2) begin
            @(negedge clk);
            rst = 1'b0;
        end else if (kind >= 0) begin
            check_eq("outcome", kind, exp_kind);
            check_eq("reads_issued", reads, exp_reads);
        end
        check_eq("write_accepts", wr_accepts, 1);
        check_eq("write_stb_cycles", wr_stb_cycles, stall_plan[0] + 1);

        // Idle with stray acks: nothing may move, o_polls keeps the last count.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("idle_quiet", {o_cyc, o_stb, o_busy, o_done, o_err}, 5'b00000);
            check_eq("idle_polls", o_polls, (kind == 2) ? 0 : exp_reads);
            i_ack   = 1'($urandom_range(0, 1));
            i_stall = 1'($urandom_range(0, 1));
        end
        i_ack = 1'b0;
    endtask

    task automatic set_plan(input int s0, input int lat_all, input logic [31:0] v0,
                            input logic [31:0] v1, input logic [31:0] v2);
        for (int i = 0; i < N_TXN; i++) begin
            stall_plan[i] = 0;
            lat_plan[i]   = lat_all;
        end
        stall_plan[0] = s0;
        val_plan[0] = v0;
        val_plan[1] = v1;
        val_plan[2] = v2;
    endtask

    initial begin
        rst       = 1'b1;
        i_trigger = 1'b0;
        i_stall   = 1'b0;
        i_ack     = 1'b0;
        i_data    = '0;
        @(negedge clk);
        check_eq("reset_bus", {o_cyc, o_stb, o_we, o_addr}, 4'b0000);
        check_eq("reset_flags", {o_busy, o_done, o_err}, 3'b000);
        check_eq("reset_polls", o_polls, 0);
        check_eq("reset_data", o_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reads return 3, 2, 0 with single-cycle acks.
        set_plan(0, 1, 32'd3, 32'd2, 32'd0);
        run_walk(0, 0);
        // Write held off by five stall cycles.
        set_plan(5, 1, 32'd0, 32'd0, 32'd0);
        run_walk(0, 0);
        // Slave never acknowledges the write.
        set_plan(0, NEVER, 32'd0, 32'd0, 32'd0);
        run_walk(0, 0);
        // Walker never goes idle: poll limit.
        set_plan(0, 0, 32'd1, 32'd1, 32'd1);
        run_walk(0, 0);
        // Reset while a status read waits for its ack, then a clean walk.
        set_plan(0, 1, 32'd5, 32'd0, 32'd0);
        lat_plan[1] = NEVER;
        run_walk(0, 1);
        set_plan(0, 2, 32'd7, 32'd0, 32'd0);
        run_walk(0, 0);
        // Trigger held through the walk; acks arriving on the last allowed cycle.
        set_plan(2, int'(ACK_TIMEOUT), 32'd9, 32'd4, 32'd0);
        run_walk(1, 0);

        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < N_TXN; i++) begin
                stall_plan[i] = int'($urandom_range(0, 3));
                lat_plan[i]   = pick_lat();
            end
            for (int i = 0; i < int'(MAX_POLLS); i++) begin
                val_plan[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 32'hFFFF));
            end
            run_walk(1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
